vram_arbiter: RTL

//  Shares one single-port synchronous video RAM between the Z8 CPU data bus and the video pixel fetcher.

---
 rtl/vram_arbiter_pkg.sv | 21 ++
 rtl/vram_arb_run_ctr.sv | 35 +++
 rtl/vram_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_pkg.sv
// rtl/vram_arbiter_pkg.sv - shared types and defaults for the video RAM arbiter
package vram_arbiter_pkg;

    // Default geometry: 8 KiB of byte-wide video RAM
    localparam int DEFAULT_AW = 13;
    localparam int DEFAULT_DW = 8;

    // CPU-side access tracker; one access outstanding at a time
    typedef enum logic [1:0] {
        CPU_IDLE   = 2'd0,
        CPU_ISSUED = 2'd1,
        CPU_WAIT   = 2'd2,
        CPU_ACK    = 2'd3
    } cpuState_t;

    // Width needed to hold a run count of 0..maxRun
    function automatic int runWidth(input int maxRun);
        return $clog2(maxRun + 1);
    endfunction

endpackage

// File: rtl/vram_arb_run_ctr.sv
// rtl/vram_arb_run_ctr.sv - saturating count of consecutive video grants made while the CPU waits
module vram_arb_run_ctr
    import vram_arbiter_pkg::*;
#(
    parameter int MAX_RUN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int W = runWidth(MAX_RUN);
    localparam logic [W-1:0] MAX_VAL = W'(MAX_RUN);

    logic [W-1:0] runCount;

    // Clear wins over increment; the count parks at MAX_VAL until cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            runCount <= '0;
        end else if (clr) begin
            runCount <= '0;
        end else if (inc && !sat) begin
            runCount <= runCount + W'(1);
        end
    end

    // Saturation tells the grant logic that video has used up its run
    always_comb begin
        sat = (runCount == MAX_VAL);
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - shares one single-port video RAM between CPU and pixel fetcher; VRAM_ARB_STATS_EN adds a CPU wait counter
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int AW          = DEFAULT_AW,
    parameter int DW          = DEFAULT_DW,
    parameter int MAX_VID_RUN = 8
) (
    input  logic          clk,
    input  logic          reset,
`ifdef VRAM_ARB_STATS_EN
    input  logic          stat_clr,
    output logic [15:0]   stat_cpu_wait,
`endif
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_gnt,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    cpuState_t cpuState;
    cpuState_t cpuNext;

    logic cpuEligible;
    logic vidGnt;
    logic cpuGnt;
    logic runSat;
    logic runInc;
    logic runClr;

    // Owner of the access currently presented on ram_*
    logic ramIsCpu;
    // Access whose read data the RAM is producing this cycle
    logic retVid;
    logic retCpu;
    logic retWe;

    // Grant decision: video by default, CPU once video has had its run
    always_comb begin
        cpuEligible = cpu_req && (cpuState == CPU_IDLE);
        vidGnt      = vid_req && (!cpuEligible || !runSat);
        cpuGnt      = cpuEligible && !vidGnt;
        runInc      = vidGnt && cpuEligible;
        runClr      = cpuGnt || !cpu_req;
        vid_gnt     = vidGnt;
    end

    vram_arb_run_ctr #(
        .MAX_RUN (MAX_VID_RUN)
    ) u_run_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (runInc),
        .clr   (runClr),
        .sat   (runSat)
    );

    // CPU tracker state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpuState <= CPU_IDLE;
        end else begin
            cpuState <= cpuNext;
        end
    end

    // CPU tracker next state: follows the access down the two-stage pipe
    always_comb begin
        cpuNext = cpuState;
        case (cpuState)
            CPU_IDLE:   if (cpuGnt) cpuNext = CPU_ISSUED;
            CPU_ISSUED: cpuNext = CPU_WAIT;
            CPU_WAIT:   cpuNext = CPU_ACK;
            CPU_ACK:    cpuNext = CPU_IDLE;
            default:    cpuNext = CPU_IDLE;
        endcase
    end

    // CPU tracker outputs: ack is a decode of the registered state
    always_comb begin
        cpu_ack = (cpuState == CPU_ACK);
    end

    // RAM command register; address and write data hold when no grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ramIsCpu  <= 1'b0;
        end else begin
            ram_en   <= vidGnt || cpuGnt;
            ram_we   <= cpuGnt && cpu_we;
            ramIsCpu <= cpuGnt;
            if (vidGnt) begin
                ram_addr <= vid_addr;
            end else if (cpuGnt) begin
                ram_addr  <= cpu_addr;
                ram_wdata <= cpu_wdata;
            end
        end
    end

    // Tag of the access the RAM samples this edge, so the return stage knows where rdata goes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retVid <= 1'b0;
            retCpu <= 1'b0;
            retWe  <= 1'b0;
        end else begin
            retVid <= ram_en && !ramIsCpu;
            retCpu <= ram_en && ramIsCpu;
            retWe  <= ram_we;
        end
    end

    // Return stage: steer RAM read data to video or CPU; CPU writes return zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vid_valid <= 1'b0;
            vid_data  <= '0;
            cpu_rdata <= '0;
        end else begin
            vid_valid <= retVid;
            if (retVid) begin
                vid_data <= ram_rdata;
            end
            if (retCpu) begin
                cpu_rdata <= retWe ? '0 : ram_rdata;
            end
        end
    end

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] statCpuWait;

    // Count cycles a ready CPU request loses arbitration; saturates rather than wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            statCpuWait <= '0;
        end else if (stat_clr) begin
            statCpuWait <= '0;
        end else if (cpuEligible && !cpuGnt && (statCpuWait != 16'hFFFF)) begin
            statCpuWait <= statCpuWait + 16'd1;
        end
    end

    assign stat_cpu_wait = statCpuWait;
`endif

endmodule
